// File: rtl/quad_decoder_if.sv
// ----------------------------------------------------------------------------
// quad_decoder_if
//   Bundles the quadrature pins, the clear controls and the decoded outputs of
//   quad_decoder into one port.
//   master : drives enc_a/enc_b/clr/err_clr, observes position/dir/step/err
//   slave  : the decoder side (inputs/outputs mirrored)
// ----------------------------------------------------------------------------
interface quad_decoder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             enc_a;     // phase A, asynchronous to clk
    logic             enc_b;     // phase B, asynchronous to clk
    logic             clr;       // synchronous clear of position (level)
    logic             err_clr;   // synchronous clear of sticky err
    logic [WIDTH-1:0] position;  // up/down count, wraps modulo 2^WIDTH
    logic             dir;       // direction of last legal step, 1 = up
    logic             step;      // one-cycle pulse per legal step
    logic             err;       // sticky illegal-transition flag

    modport master (
        output enc_a,
        output enc_b,
        output clr,
        output err_clr,
        input  position,
        input  dir,
        input  step,
        input  err
    );

    modport slave (
        input  enc_a,
        input  enc_b,
        input  clr,
        input  err_clr,
        output position,
        output dir,
        output step,
        output err
    );
endinterface

// File: rtl/quad_decoder.sv
// ----------------------------------------------------------------------------
// quad_decoder
//   Receive-side decoder for a 2-phase quadrature (Gray-code) pin pair.
//   Pins are synchronised, jointly glitch-filtered, then each accepted
//   transition is decoded into an up/down step of a wrapping position count.
//   Double transitions (both pins flipping at once) set a sticky error.
//
//   Ports:
//     clk  - single clock, all logic on posedge
//     rst  - asynchronous active-high reset
//     bus  - quad_decoder_if.slave: enc_a, enc_b, clr, err_clr in;
//            position, dir, step, err out
//
//   Pipeline (defaults): pin sampled at edge 0, synced pair at edge 1,
//   filter accepts at edge 4, position/dir/step/err update at edge 5.
// ----------------------------------------------------------------------------
module quad_decoder #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input logic           clk,
    input logic           rst,
    quad_decoder_if.slave bus
);

    localparam int unsigned CntW = $clog2(FILT_LEN + 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN);

    // Synchroniser chains; the last stage is the synced value.
    logic [SYNC_STAGES-1:0] sync_a_q;
    logic [SYNC_STAGES-1:0] sync_b_q;
    logic [1:0]             s;          // {a, b} after synchronisation

    // Filter state
    logic [1:0]      s_prev_q;          // synced pair one cycle ago
    logic [1:0]      filt_q, filt_d;    // accepted {a, b}
    logic [CntW-1:0] cnt_q, cnt_d;      // cycles s has been stable and != filt
    logic [CntW-1:0] stable;
    logic            accept;
    logic            primed_q, primed_d;

    // Decoded transition, one cycle pulses feeding the output stage
    logic up_q, up_d;
    logic dn_q, dn_d;
    logic ill_q, ill_d;

    // Output registers
    logic [WIDTH-1:0] position_q, position_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;

    // Gray phase index: 00 -> 0, 10 -> 1, 11 -> 2, 01 -> 3 (counting up).
    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        logic [1:0] ph;
        ph = 2'd0;
        case (ab)
            2'b00:   ph = 2'd0;
            2'b10:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

    assign s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // Filter and decode next-state
    always_comb begin
        logic [1:0] delta;

        // Stability count including the current cycle, saturating at FILT_LEN.
        if (s != s_prev_q) begin
            stable = CntOne;
        end else if (cnt_q >= CntMax) begin
            stable = CntMax;
        end else begin
            stable = cnt_q + CntOne;
        end

        accept   = (s != filt_q) && (stable >= CntMax);
        cnt_d    = ((s == filt_q) || accept) ? '0 : stable;
        filt_d   = accept ? s : filt_q;
        primed_d = primed_q | accept;

        // The priming acceptance only loads filt; it never decodes.
        delta = phase_of(s) - phase_of(filt_q);
        up_d  = accept && primed_q && (delta == 2'd1);
        dn_d  = accept && primed_q && (delta == 2'd3);
        ill_d = accept && primed_q && (delta == 2'd2);
    end

    // Output stage next-state
    always_comb begin
        position_d = position_q;
        if (up_q) begin
            position_d = position_q + WIDTH'(1);
        end else if (dn_q) begin
            position_d = position_q - WIDTH'(1);
        end
        // Clear overrides a coincident step; dir/step still follow the step.
        if (bus.clr) begin
            position_d = '0;
        end

        if (up_q) begin
            dir_d = 1'b1;
        end else if (dn_q) begin
            dir_d = 1'b0;
        end else begin
            dir_d = dir_q;
        end

        step_d = up_q | dn_q;

        // Setting wins over a same-edge clear.
        if (ill_q) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            s_prev_q   <= 2'b00;
            filt_q     <= 2'b00;
            cnt_q      <= '0;
            primed_q   <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            ill_q      <= 1'b0;
            position_q <= '0;
            dir_q      <= 1'b1;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync_a_q   <= {sync_a_q[SYNC_STAGES-2:0], bus.enc_a};
            sync_b_q   <= {sync_b_q[SYNC_STAGES-2:0], bus.enc_b};
            s_prev_q   <= s;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            primed_q   <= primed_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            ill_q      <= ill_d;
            position_q <= position_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign bus.position = position_q;
    assign bus.dir      = dir_q;
    assign bus.step     = step_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// ----------------------------------------------------------------------------
// tb_quad_decoder
//   Directed bench for quad_decoder with default parameters
//   (WIDTH=16, SYNC_STAGES=2, FILT_LEN=3). Step pulses are tallied in tick().
// ----------------------------------------------------------------------------
module tb_quad_decoder;

    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   steps  = 0;

    quad_decoder_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .FILT_LEN    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance n clocks, sampling 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.step === 1'b1) steps++;
        end
    endtask

    task automatic pins(input logic a, input logic b, input int n);
        bus.enc_a = a;
        bus.enc_b = b;
        tick(n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.enc_a   = 1'b0;
        bus.enc_b   = 1'b0;
        bus.clr     = 1'b0;
        bus.err_clr = 1'b0;
        tick(2);
        chk("reset_position", 32'(bus.position), 32'h0);
        chk("reset_dir", 32'(bus.dir), 32'h1);
        chk("reset_step", 32'(bus.step), 32'h0);
        chk("reset_err", 32'(bus.err), 32'h0);
        rst = 1'b0;
        tick(2);

        // Priming: first acceptance 00 -> 10 does not count.
        steps = 0;
        pins(1'b1, 1'b0, 8);
        chk("prime_steps", 32'(steps), 32'd0);
        chk("prime_position", 32'(bus.position), 32'h0);
        pins(1'b1, 1'b1, 8);
        pins(1'b0, 1'b1, 8);
        pins(1'b0, 1'b0, 8);
        chk("up3_steps", 32'(steps), 32'd3);
        chk("up3_position", 32'(bus.position), 32'h3);
        chk("up3_dir", 32'(bus.dir), 32'h1);

        // 16 down steps from 3 -> -13.
        steps = 0;
        for (int r = 0; r < 4; r++) begin
            pins(1'b0, 1'b1, 8);
            pins(1'b1, 1'b1, 8);
            pins(1'b1, 1'b0, 8);
            pins(1'b0, 1'b0, 8);
        end
        chk("down16_steps", 32'(steps), 32'd16);
        chk("down16_position", 32'(bus.position), 32'hFFF3);
        chk("down16_dir", 32'(bus.dir), 32'h0);

        // Glitch on B: 2-clock pulse is filtered out.
        steps = 0;
        pins(1'b0, 1'b1, 2);
        pins(1'b0, 1'b0, 8);
        chk("glitch2_steps", 32'(steps), 32'd0);
        chk("glitch2_position", 32'(bus.position), 32'hFFF3);
        chk("glitch2_err", 32'(bus.err), 32'h0);
        // 3-clock pulse passes: down (00->01) then up (01->00).
        pins(1'b0, 1'b1, 3);
        pins(1'b0, 1'b0, 10);
        chk("pulse3_steps", 32'(steps), 32'd2);
        chk("pulse3_position", 32'(bus.position), 32'hFFF3);
        chk("pulse3_dir", 32'(bus.dir), 32'h1);
        chk("pulse3_err", 32'(bus.err), 32'h0);

        // Illegal 00 -> 11.
        steps = 0;
        pins(1'b1, 1'b1, 8);
        chk("illegal_err", 32'(bus.err), 32'h1);
        chk("illegal_position", 32'(bus.position), 32'hFFF3);
        chk("illegal_steps", 32'(steps), 32'd0);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        chk("err_clr", 32'(bus.err), 32'h0);
        // Illegal 11 -> 00 decoded on the same edge as err_clr: set wins.
        pins(1'b0, 1'b0, 5);
        chk("err_before_decode", 32'(bus.err), 32'h0);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        chk("err_set_wins", 32'(bus.err), 32'h1);
        chk("illegal2_position", 32'(bus.position), 32'hFFF3);
        tick(4);

        // Latency: step high after the 6th edge following the pin change.
        steps = 0;
        pins(1'b1, 1'b0, 5);
        chk("latency_step_early", 32'(bus.step), 32'h0);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        chk("latency_step", 32'(bus.step), 32'h1);
        chk("clr_wins_position", 32'(bus.position), 32'h0);
        chk("clr_dir", 32'(bus.dir), 32'h1);
        tick(1);
        chk("step_one_cycle", 32'(bus.step), 32'h0);
        tick(4);
        chk("latency_steps", 32'(steps), 32'd1);

        // Wrap: down from 0, then up from all-ones.
        pins(1'b0, 1'b0, 8);
        chk("wrap_down_position", 32'(bus.position), 32'hFFFF);
        chk("wrap_down_dir", 32'(bus.dir), 32'h0);
        pins(1'b1, 1'b0, 8);
        chk("wrap_up_position", 32'(bus.position), 32'h0);
        chk("wrap_up_dir", 32'(bus.dir), 32'h1);
        pins(1'b0, 1'b0, 8);
        chk("pre_rst_position", 32'(bus.position), 32'hFFFF);
        chk("pre_rst_dir", 32'(bus.dir), 32'h0);

        // Asynchronous reset just before a pending step.
        pins(1'b0, 1'b1, 5);
        rst = 1'b1;
        #1;
        chk("midrst_position", 32'(bus.position), 32'h0);
        chk("midrst_dir", 32'(bus.dir), 32'h1);
        chk("midrst_step", 32'(bus.step), 32'h0);
        chk("midrst_err", 32'(bus.err), 32'h0);
        tick(2);
        rst = 1'b0;

        // Priming repeats after reset, then 01 -> 00 counts up.
        steps = 0;
        tick(8);
        chk("reprime_steps", 32'(steps), 32'd0);
        chk("reprime_position", 32'(bus.position), 32'h0);
        pins(1'b0, 1'b0, 8);
        chk("after_reprime_steps", 32'(steps), 32'd1);
        chk("after_reprime_position", 32'(bus.position), 32'h1);
        chk("after_reprime_dir", 32'(bus.dir), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
